// File: rtl/cordic_share_arb.sv
// rtl/cordic_share_arb.sv - round-robin arbiter sharing one iterative cordic core among N requesters
// Optional wait watchdog with timeout_err output: define CORDIC_ARB_TIMEOUT_EN.
module cordic_share_arb #(
    parameter  int N       = 2,
    parameter  int W       = 32,
    parameter  int TIMEOUT = 256,
    localparam int GW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_x,
    input  logic [N*W-1:0] req_y,
    output logic [N-1:0]   done,
    output logic [W-1:0]   res_angle,
    output logic [W-1:0]   res_mozhi,
    output logic           busy,
    output logic [GW-1:0]  grant_id,
    output logic [W-1:0]   cor_x,
    output logic [W-1:0]   cor_y,
    output logic           cor_start,
    input  logic [W-1:0]   cor_angle,
    input  logic [W-1:0]   cor_mozhi,
    input  logic           cor_finished
`ifdef CORDIC_ARB_TIMEOUT_EN
    ,
    output logic           timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [W-1:0]  cx_q, cx_d;
    logic [W-1:0]  cy_q, cy_d;
    logic [W-1:0]  ang_q, ang_d;
    logic [W-1:0]  mag_q, mag_d;

    logic          pick_vld;
    logic [GW-1:0] pick_idx;
    logic [GW:0]   scan_idx;

    if (N < 2 || N > 8 || W < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cordic_share_arb: unsupported parameter set");
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          to_q, to_d;
    logic          wd_expire;

    // The transition out of WAIT is the cycle in which the count reaches TIMEOUT.
    assign wd_expire = (wcnt_q == CW'(TIMEOUT - 1));
`endif

    // Scan ptr, ptr+1, ... modulo N and take the first active request.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr_q} + (GW+1)'(k);
            if (scan_idx >= (GW+1)'(N)) begin
                scan_idx = scan_idx - (GW+1)'(N);
            end
            if (!pick_vld && req[scan_idx[GW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ang_q   <= '0;
            mag_q   <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wcnt_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ang_q   <= ang_d;
            mag_q   <= mag_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            to_q    <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ang_d   = ang_q;
        mag_d   = mag_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_ISSUE;
                    grant_d = pick_idx;
                    cx_d    = req_x[pick_idx*W +: W];
                    cy_d    = req_y[pick_idx*W +: W];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
                wcnt_d  = '0;
                to_d    = 1'b0;
`endif
            end
            S_WAIT: begin
                if (cor_finished) begin
                    state_d = S_DELIVER;
                    ang_d   = cor_angle;
                    mag_d   = cor_mozhi;
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = S_DELIVER;
                    ang_d   = '0;
                    mag_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
`endif
            end
            S_DELIVER: begin
                state_d = S_IDLE;
                ptr_d   = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done      = '0;
        cor_start = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        if (state_q == S_DELIVER) begin
            done[grant_q] = 1'b1;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        timeout_err = (state_q == S_DELIVER) && to_q;
`endif
    end

    assign grant_id  = grant_q;
    assign cor_x     = cx_q;
    assign cor_y     = cy_q;
    assign res_angle = ang_q;
    assign res_mozhi = mag_q;

endmodule

// File: tb/tb_cordic_share_arb.sv
// tb/tb_cordic_share_arb.sv - self-checking bench for cordic_share_arb with a behavioural cordic core
`timescale 1ns/1ps
module tb_cordic_share_arb;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int GW = 2;
    localparam int L  = 34;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic [N-1:0]   done;
    logic [W-1:0]   res_angle;
    logic [W-1:0]   res_mozhi;
    logic           busy;
    logic [GW-1:0]  grant_id;
    logic [W-1:0]   cor_x;
    logic [W-1:0]   cor_y;
    logic           cor_start;
    logic [W-1:0]   cor_angle    = '0;
    logic [W-1:0]   cor_mozhi    = '0;
    logic           cor_finished = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    logic           timeout_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int          opx [N];
    int          opy [N];
    int          age [N];
    logic [N-1:0] pend;

    always #5 clk = ~clk;

    cordic_share_arb #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_x        (req_x),
        .req_y        (req_y),
        .done         (done),
        .res_angle    (res_angle),
        .res_mozhi    (res_mozhi),
        .busy         (busy),
        .grant_id     (grant_id),
        .cor_x        (cor_x),
        .cor_y        (cor_y),
        .cor_start    (cor_start),
        .cor_angle    (cor_angle),
        .cor_mozhi    (cor_mozhi),
        .cor_finished (cor_finished)
`ifdef CORDIC_ARB_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    function automatic int ref_mag(input int x, input int y);
        real r;
        r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        return $rtoi(r);
    endfunction

    function automatic int ref_ang(input int x, input int y);
        return $rtoi($atan2(real'(y), real'(x)) * 65536.0);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Core model: result appears core_lat cycles after the start cycle; outputs carry junk otherwise.
    int core_cnt = 0;
    int core_lat = L;
    int core_xl  = 0;
    int core_yl  = 0;
    always @(negedge clk) begin
        cor_finished = 1'b0;
        cor_angle    = $urandom;
        cor_mozhi    = $urandom;
        if (cor_start === 1'b1) begin
            core_cnt = core_lat;
            core_xl  = cor_x;
            core_yl  = cor_y;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                cor_finished = 1'b1;
                cor_angle    = ref_ang(core_xl, core_yl);
                cor_mozhi    = ref_mag(core_xl, core_yl);
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_op(input int i, input int x, input int y);
        opx[i] = x;
        opy[i] = y;
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic raise(input int i);
        set_op(i, int'($urandom_range(0, 2097151)) - 1048576,
                  int'($urandom_range(0, 2097151)) - 1048576);
        pend[i] = 1'b1;
        age[i]  = 0;
        req     = pend;
    endtask

    task automatic wait_done(input int budget, output int who, output int cyc,
                             output int first_start, output int starts);
        who         = -1;
        cyc         = budget;
        first_start = -1;
        starts      = 0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (cor_start === 1'b1) begin
                starts++;
                if (first_start < 0) first_start = c;
            end
            if (done !== '0) begin
                chk("done_onehot", $countones(done), 1);
                for (int i = 0; i < N; i++) begin
                    if (done[i] === 1'b1) who = i;
                end
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   who, cyc, fs, st, cnt, m_ptr, exp_who;
        bit   first;

        rst_n = 1'b0;
        req   = '0;
        req_x = '0;
        req_y = '0;
        pend  = '0;
        step();
        step();
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cor_start", cor_start, 0);
        chk("rst_cor_x", cor_x, 0);
        chk("rst_cor_y", cor_y, 0);
        chk("rst_angle", res_angle, 0);
        chk("rst_mozhi", res_mozhi, 0);
        chk("rst_grant", grant_id, 0);
`ifdef CORDIC_ARB_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            step();
            if (cor_start !== 1'b0 || busy !== 1'b0 || done !== '0) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        // single requester, latency and result hold
        set_op(0, 3, 4);
        req = 3'b001;
        wait_done(60, who, cyc, fs, st);
        chk("single_who", who, 0);
        chk("single_start_cyc", fs, 1);
        chk("single_starts", st, 1);
        chk("single_done_cyc", cyc, L + 2);
        chk("single_mozhi", $signed(res_mozhi), 5);
        chk("single_angle", $signed(res_angle), ref_ang(3, 4));
        chk("single_grant", grant_id, 0);
        req = '0;
        step();
        chk("single_busy_after", busy, 0);
        repeat (3) step();
        chk("single_hold", $signed(res_mozhi), 5);

        // two requesters held high alternate
        do_reset();
        set_op(0, 100, -100);
        set_op(1, 373, 818);
        req = 3'b011;
        for (int k = 0; k < 4; k++) begin
            wait_done(60, who, cyc, fs, st);
            chk("rr_who", who, k % 2);
            chk("rr_latency", cyc, (k == 0) ? L + 2 : L + 3);
            chk("rr_mozhi", $signed(res_mozhi), (k % 2 == 0) ? ref_mag(100, -100) : ref_mag(373, 818));
            chk("rr_angle", $signed(res_angle), (k % 2 == 0) ? ref_ang(100, -100) : ref_ang(373, 818));
        end
        req = '0;

        // operands change while the core is busy
        step();
        set_op(0, 6, 8);
        req = 3'b001;
        repeat (6) step();
        set_op(0, 818, 373);
        step();
        chk("hold_cor_x", $signed(cor_x), 6);
        chk("hold_cor_y", $signed(cor_y), 8);
        wait_done(60, who, cyc, fs, st);
        chk("hold_who", who, 0);
        chk("hold_mozhi", $signed(res_mozhi), 10);
        chk("hold_angle", $signed(res_angle), ref_ang(6, 8));
        req = '0;

        // asynchronous reset during WAIT, late finish ignored
        step();
        set_op(0, 3, 4);
        req = 3'b001;
        repeat (10) step();
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cor_x", cor_x, 0);
        step();
        rst_n = 1'b1;
        req   = '0;
        cnt = 0;
        repeat (40) begin
            step();
            if (done !== '0 || busy !== 1'b0) cnt++;
        end
        chk("abort_finish_ignored", cnt, 0);
        set_op(0, 5, 12);
        set_op(1, 8, 15);
        req = 3'b011;
        wait_done(60, who, cyc, fs, st);
        chk("post_abort_who0", who, 0);
        chk("post_abort_mozhi0", $signed(res_mozhi), 13);
        req[0] = 1'b0;
        wait_done(60, who, cyc, fs, st);
        chk("post_abort_who1", who, 1);
        chk("post_abort_mozhi1", $signed(res_mozhi), 17);
        req = '0;

        // randomized request patterns against a round-robin model
        do_reset();
        m_ptr = 0;
        pend  = '0;
        first = 1'b1;
        for (int i = 0; i < N; i++) begin
            age[i] = 0;
            if ($urandom_range(0, 1) == 1) raise(i);
        end
        if (pend == '0) raise(0);
        for (int t = 0; t < 24; t++) begin
            exp_who = rr_pick(pend, m_ptr);
            wait_done(60, who, cyc, fs, st);
            chk("rnd_who", who, exp_who);
            chk("rnd_latency", cyc, first ? L + 2 : L + 3);
            chk("rnd_mozhi", $signed(res_mozhi), ref_mag(opx[exp_who], opy[exp_who]));
            chk("rnd_angle", $signed(res_angle), ref_ang(opx[exp_who], opy[exp_who]));
            chk("rnd_wait_bound", age[exp_who] <= N - 1, 1);
            first = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != exp_who && pend[i]) age[i]++;
            end
            pend[exp_who] = 1'b0;
            req   = pend;
            m_ptr = (exp_who + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (i != exp_who && !pend[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            if (pend == '0) raise((exp_who + 1) % N);
        end
        req  = '0;
        pend = '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
        // watchdog expires before the core answers
        do_reset();
        core_lat = 20;
        set_op(0, 7, 24);
        req = 3'b001;
        wait_done(40, who, cyc, fs, st);
        chk("to_who", who, 0);
        chk("to_start_cyc", fs, 1);
        chk("to_done_cyc", cyc, TO + 2);
        chk("to_err", timeout_err, 1);
        chk("to_angle", res_angle, 0);
        chk("to_mozhi", res_mozhi, 0);
        req = '0;
        cnt = 0;
        repeat (10) begin
            step();
            if (done !== '0 || timeout_err !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("to_late_ignored", cnt, 0);
        core_lat = L;
        set_op(1, 20, 21);
        req = 3'b010;
        wait_done(60, who, cyc, fs, st);
        chk("to_next_who", who, 1);
        chk("to_next_cyc", cyc, L + 2);
        chk("to_next_err", timeout_err, 0);
        chk("to_next_mozhi", $signed(res_mozhi), 29);
        req = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
